neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
- REQ-001: Parameter N_IN, default 2, number of neuron inputs (legal range 1..16).
- REQ-002: Parameter ACC_W, default 40, accumulator width in bits (Q(ACC_W-16).16).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-005: in_valid  input  1  x_in/w_in/bias_in are valid this cycle.
- REQ-006: in_ready  output  1  block can accept a new operand set.
- REQ-007: x_in  input  16*N_IN  packed signed Q8.8 activations; element i at bits [16i+15:16i].
- REQ-008: w_in  input  16*N_IN  packed signed Q8.8 weights, same packing as x_in.
- REQ-009: bias_in  input  16  signed Q8.8 bias.
- REQ-010: out_valid  output  1  z_out is valid and held stable.
- REQ-011: out_ready  input  1  downstream (sigmoid stage) accepts z_out.
- REQ-012: z_out  output  16  signed Q8.8 pre-activation sum, ready to drive the sigmoid input.
- REQ-013: sat  output  1  z_out was clipped by saturation; qualified by out_valid.

Function
- REQ-014: The FSM SHALL have three states: IDLE, ACCUM, DONE.
- REQ-015: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
- REQ-016: In IDLE, on in_valid=1: capture x_in, w_in, bias_in into registers; load accumulator with sign-extended bias_in shifted left 8; clear index counter; go to ACCUM.
- REQ-017: In ACCUM, each cycle SHALL add one full-precision 32-bit signed product x[i]*w[i] (Q16.16) to the accumulator, i from 0 to N_IN-1 in order.
- REQ-018: After the product with i=N_IN-1 is added, the next edge SHALL compute the result and enter DONE.
- REQ-019: Result = accumulator arithmetic-shifted right by 8 (floor truncation, no rounding), then saturated to [-32768, 32767].
- REQ-020: sat SHALL be 1 exactly when the shifted value lies outside [-32768, 32767].
- REQ-021: Latency SHALL be N_IN+1 cycles: acceptance at edge k gives out_valid=1 after edge k+N_IN+1 (3 cycles for N_IN=2).
- REQ-022: In DONE, z_out and sat SHALL remain stable while out_ready=0; on out_ready=1, go to IDLE at that edge.
- REQ-023: New input SHALL NOT be accepted in the DONE cycle in which the output is consumed; earliest next acceptance is the following cycle (no overlap).
- REQ-024: Changes on x_in/w_in/bias_in after acceptance SHALL NOT affect the in-flight result.
- REQ-025: The accumulator SHALL NOT overflow internally for N_IN<=16 with ACC_W=40.
- REQ-026: in_valid and out_ready outside IDLE and DONE respectively SHALL be ignored.

Reset
- REQ-027: On rst_n=0, the block SHALL asynchronously enter IDLE with in_ready=1, out_valid=0, z_out=0, sat=0, accumulator=0, index=0.
- REQ-028: Reset asserted mid-ACCUM or mid-DONE SHALL discard the operation; no out_valid may follow after deassertion without a new acceptance.
- REQ-029: After rst_n deasserts, the first rising edge SHALL be able to accept in_valid.

Structure
- REQ-030: Shared package nn_pkg SHALL hold DATA_W=16, FRAC_BITS=8, Q88_ONE=16'sh0100, Q88_MAX=32767, Q88_MIN=-32768 and the FSM state typedef; the sigmoid stage uses the same constants.
- REQ-031: One sub-module, q88_sat (ACC_W-bit signed in, shift by FRAC_BITS, 16-bit saturated out plus sat flag, combinational), SHALL implement REQ-019/020.

Verification
- REQ-032: x=[256,256], w=[512,-256], bias=128 -> z_out=384, sat=0, out_valid exactly 3 cycles after acceptance.
- REQ-033: x=[32767,32767], w=[32767,32767], bias=0 -> z_out=32767, sat=1; x=[-32768,-32768], w=[32767,32767] -> z_out=-32768, sat=1.
- REQ-034: Truncation: x=[1,0], w=[1,0], bias=0 -> z_out=0; x=[-1,0], w=[1,0], bias=0 -> z_out=-1 (floor).
- REQ-035: Back-pressure: out_ready=0 for 5 cycles -> z_out/sat stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, accept next operand set one cycle later.
- REQ-036: Reset mid-ACCUM (edge k+1 of REQ-032 stimulus) -> outputs at reset values, no out_valid thereafter until a new acceptance; the next operation produces the correct result.
- REQ-037: Randomised operands for N_IN=2 and N_IN=4 against a reference model of REQ-019 -> exact z_out/sat match over 10000 transactions.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared fixed-point constants and FSM state encoding for the neuron datapath.
// Combinational definitions only; no latency.
// No flow control of its own; also consumed by the sigmoid stage.
package nn_pkg;

  // Q8.8 number format shared by the MAC and the sigmoid stage
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int PROD_W    = 2 * DATA_W;

  localparam logic signed [DATA_W-1:0] Q88_ONE = 16'sh0100;
  localparam logic signed [DATA_W-1:0] Q88_MAX = 16'sh7FFF;  //  32767
  localparam logic signed [DATA_W-1:0] Q88_MIN = 16'sh8000;  // -32768

  // MAC sequencer states (plain constants so older flows can consume them)
  typedef logic [1:0] nn_state_t;
  localparam nn_state_t ST_IDLE  = 2'd0;
  localparam nn_state_t ST_ACCUM = 2'd1;
  localparam nn_state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/q88_sat.sv
// Rescales a Q(ACC_W-16).16 accumulator to Q8.8 with floor truncation and clipping.
// Purely combinational, zero latency.
// No flow control; caller qualifies the outputs.
module q88_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] z_o,
  output logic                     sat_o
);

  // Bits from the Q8.8 sign bit upward; the value fits in 16 bits only if they all agree.
  localparam int UPPER_W = ACC_W - DATA_W + 1;

  logic signed [ACC_W-1:0] shifted;
  logic [UPPER_W-1:0]      upper;
  logic                    ovf;

  // Arithmetic shift (floor toward -inf), then clip to the Q8.8 range.
  always_comb begin
    shifted = acc_i >>> FRAC_BITS;
    upper   = shifted[ACC_W-1:DATA_W-1];
    ovf     = !((&upper) || !(|upper));
    sat_o   = ovf;
    if (!ovf) begin
      z_o = shifted[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      z_o = Q88_MIN;
    end else begin
      z_o = Q88_MAX;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate neuron: z = sat((bias<<8 + sum x[i]*w[i]) >>> 8) in Q8.8.
// Latency N_IN+1 cycles from acceptance to out_valid; one operation in flight at a time.
// in_ready only in IDLE; result is held in DONE until out_ready, with no overlap on consume.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int ACC_W = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*N_IN-1:0]   x_in,
  input  logic [DATA_W*N_IN-1:0]   w_in,
  input  logic [DATA_W-1:0]        bias_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        z_out,
  output logic                     sat
);

  // The index runs 0..N_IN: values below N_IN select a product, N_IN is the rescale cycle.
  localparam int              IDX_W    = $clog2(N_IN + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN);

  nn_state_t                state_q, state_d;
  logic [DATA_W*N_IN-1:0]   x_q, x_d;
  logic [DATA_W*N_IN-1:0]   w_q, w_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        z_q, z_d;
  logic                     sat_q, sat_d;

  logic signed [DATA_W-1:0] x_sel, w_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [DATA_W-1:0] sat_z;
  logic                     sat_flag;

  // Pick operand pair idx_q from the captured vectors and form the Q16.16 product.
  always_comb begin
    x_sel = '0;
    w_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IDX_W'(i)) begin
        x_sel = x_q[DATA_W*i +: DATA_W];
        w_sel = w_q[DATA_W*i +: DATA_W];
      end
    end
    prod     = x_sel * w_sel;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias_in[DATA_W-1]}}, bias_in, {FRAC_BITS{1'b0}}};
  end

  q88_sat #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc_i (acc_q),
    .z_o   (sat_z),
    .sat_o (sat_flag)
  );

  // Sequencer: capture in IDLE, one product per cycle in ACCUM, hold result in DONE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    w_d     = w_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    z_d     = z_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          w_d     = w_in;
          acc_d   = bias_ext;
          idx_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (idx_q == IDX_LAST) begin
          z_d     = sat_z;
          sat_d   = sat_flag;
          state_d = ST_DONE;
        end else begin
          acc_d = acc_q + prod_ext;
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      z_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign z_out     = z_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (N_IN=2): directed vectors plus reference-checked random traffic.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic [15:0] bias_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z_out;
  logic        sat;

  always #5 clk = ~clk;

  neuron_mac #(
    .N_IN  (2),
    .ACC_W (40)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z_out     (z_out),
    .sat       (sat)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic        prev_vld = 1'b0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Cycle counter and acceptance timestamp for the latency check.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_cyc <= cyc + 1;
  end

  // Monitor: latency on each new result, and scoreboard compare on every handshake.
  always @(negedge clk) begin
    if (out_valid && !prev_vld)
      chk("latency", (cyc - acc_cyc) == 3, cyc - acc_cyc, 3);
    prev_vld = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1'b0, {15'd0, sat, z_out}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {sat, z_out} == mon_e, {15'd0, sat, z_out}, {15'd0, mon_e});
      end
    end
  end

  function automatic logic [16:0] ref_mac(input logic [15:0] x0, x1, w0, w1, b);
    longint acc;
    longint sh;
    acc = longint'($signed(b)) * 256
        + longint'($signed(x0)) * longint'($signed(w0))
        + longint'($signed(x1)) * longint'($signed(w1));
    sh = acc >>> 8;
    if (sh > 32767)  return {1'b1, 16'h7FFF};
    if (sh < -32768) return {1'b1, 16'h8000};
    return {1'b0, sh[15:0]};
  endfunction

  // Present one operand set, wait (bounded) for acceptance, then scramble the inputs.
  task automatic send(input logic [15:0] x0, x1, w0, w1, b, input logic [15:0] ez, input bit es);
    int n;
    n = 0;
    x_in     = {x1, x0};
    w_in     = {w1, w0};
    bias_in  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 1'b0, 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({es, ez});
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = $urandom;
    w_in     = $urandom;
    bias_in  = 16'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size() == 0, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int          n;
    logic [15:0] r0, r1, r2, r3, r4;
    logic [16:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    w_in      = '0;
    bias_in   = '0;
    #12;
    chk("rst_in_ready",  in_ready == 1'b1,  in_ready,  1);
    chk("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("rst_z_out",     z_out == 16'h0,    z_out,     0);
    chk("rst_sat",       sat == 1'b0,       sat,       0);
    rst_n = 1'b1;

    // Directed vectors: x0, x1, w0, w1, bias -> z, sat
    send(16'h0100, 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0180, 1'b0);
    send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
    send(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000, 1'b1);
    send(16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    send(16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFED4, 16'hFED4, 1'b0);
    send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h0001, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1);
    send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h8000, 1'b1);
    send(16'h0180, 16'hFF00, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 1'b0);
    wait_drain();

    // Back-pressure: hold DONE for 5 cycles while in_valid pulses with junk.
    out_ready = 1'b0;
    send(16'h0100, 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0180, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", out_valid == 1'b1, out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      x_in     = $urandom;
      w_in     = $urandom;
      bias_in  = 16'($urandom);
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_hold", out_valid && !in_ready && z_out == 16'h0180 && !sat,
          {14'd0, out_valid, in_ready, sat, z_out}, {14'd0, 1'b1, 1'b0, 1'b0, 16'h0180});
    end
    // Consume with in_valid already high: must not be taken in the DONE cycle.
    x_in      = {16'h0000, 16'hFFFF};
    w_in      = {16'h0000, 16'h0001};
    bias_in   = 16'h0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_consume", in_ready && !out_valid, {out_valid, in_ready}, 2'b01);
    send(16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
    wait_drain();

    // Reset one edge after acceptance: operation discarded, outputs back to reset values.
    send(16'h0100, 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0180, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_accum", in_ready && !out_valid && z_out == 16'h0 && !sat,
        {14'd0, in_ready, out_valid, sat, z_out}, {14'd0, 1'b1, 1'b0, 1'b0, 16'h0});
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_valid_after_rst", !seen, seen, 0);
    send(16'h0100, 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 16'h0180, 1'b0);
    wait_drain();

    // Random operands against the reference model.
    for (int t = 0; t < 2000; t++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      r2 = 16'($urandom);
      r3 = 16'($urandom);
      r4 = 16'($urandom);
      e  = ref_mac(r0, r1, r2, r3, r4);
      send(r0, r1, r2, r3, r4, e[15:0], e[16]);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
